// File: rtl/markov_pkg.sv
// Shared types and constants for the markov DFE sequencer slice.
package markov_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    // Table depth of a one-tap DFE: 4 tx symbols x 7 states x 3 thresholds
    localparam int unsigned N_ENTRIES_1TAP = 84;
    // Probability index value meaning "no table write this cycle"
    localparam logic [31:0] PROB_IDX_NONE  = 32'hFFFF_FFFF;
    // Cumulative thresholds per (symbol, state) group
    localparam int unsigned DFE_GROUP      = 3;

endpackage

// File: rtl/markov_table_writer.sv
// Streams cumulative-probability words into the DFE table port.
// Optional build macro MARKOV_SEQ_MONO_CHECK_EN adds a per-group
// monotonic checker; without it cfg_err is tied low.
module markov_table_writer
    import markov_pkg::*;
#(
    parameter int unsigned PROB_W    = 32,
    parameter int unsigned N_ENTRIES = N_ENTRIES_1TAP
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_en,
    input  logic              clear,
    input  logic              abort,
    input  logic              cfg_valid,
    input  logic [PROB_W-1:0] cfg_data,
    output logic [31:0]       prob_idx,
    output logic [PROB_W-1:0] prob_in,
    output logic              last_c,
    output logic              mono_err_c,
    output logic              cfg_err
);

    localparam int unsigned LCNT_W = $clog2(N_ENTRIES);

    logic [LCNT_W-1:0] load_cnt;
    logic              hs_c;

    assign hs_c   = load_en & cfg_valid;
    assign last_c = hs_c & (load_cnt == LCNT_W'(N_ENTRIES - 1));

    // Load counter plus registered index/data so the DFE writes one edge later
    always_ff @(posedge clk) begin
        if (!rstn) begin
            load_cnt <= '0;
            prob_idx <= PROB_IDX_NONE;
            prob_in  <= '0;
        end else begin
            if (clear) begin
                load_cnt <= '0;
            end else if (hs_c) begin
                load_cnt <= load_cnt + LCNT_W'(1);
            end

            if (hs_c && !abort) begin
                prob_idx <= 32'(load_cnt);
                prob_in  <= cfg_data;
            end else begin
                prob_idx <= PROB_IDX_NONE;
            end
        end
    end

`ifdef MARKOV_SEQ_MONO_CHECK_EN
    localparam int unsigned GRP_W = $clog2(DFE_GROUP);

    logic [GRP_W-1:0] grp;

    // prob_in still holds the previously accepted word, i.e. the group predecessor
    assign mono_err_c = hs_c & (grp != '0) & (cfg_data < prob_in);

    // Position inside the threshold group and sticky error flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            grp     <= '0;
            cfg_err <= 1'b0;
        end else if (clear) begin
            grp     <= '0;
            cfg_err <= 1'b0;
        end else if (hs_c) begin
            grp <= (grp == GRP_W'(DFE_GROUP - 1)) ? '0 : grp + GRP_W'(1);
            if (mono_err_c) begin
                cfg_err <= 1'b1;
            end
        end
    end
`else
    assign mono_err_c = 1'b0;
    assign cfg_err    = 1'b0;
`endif

endmodule

// File: rtl/markov_dfe_seq_ctrl.sv
// Sequencer for one markov_1tap_dfe_32 instance: loads the probability
// table with the DFE held in reset, then gates symbols through it for a
// programmed run length. Optional build macro MARKOV_SEQ_MONO_CHECK_EN
// enables the table monotonic check in markov_table_writer.
module markov_dfe_seq_ctrl
    import markov_pkg::*;
#(
    parameter int unsigned PROB_W    = 32,
    parameter int unsigned N_ENTRIES = N_ENTRIES_1TAP,
    parameter int unsigned CNT_W     = 48
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  run_len,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [PROB_W-1:0] cfg_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              dfe_rstn,
    output logic              dfe_en,
    output logic [PROB_W-1:0] dfe_prob_in,
    output logic [31:0]       dfe_prob_idx,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sym_count,
    output logic              cfg_err
);

    seq_state_t       state;
    logic [CNT_W-1:0] run_len_q;
    logic             load_clear;
    logic             last_word;
    logic             mono_err;

    // Handshake and gating decodes of the registered state
    assign cfg_ready  = (state == LOAD);
    assign src_ready  = (state == RUN);
    assign dfe_en     = (state == RUN) & src_valid;
    assign load_clear = (state == IDLE) & start & ~abort;

    markov_table_writer #(
        .PROB_W    (PROB_W),
        .N_ENTRIES (N_ENTRIES)
    ) u_writer (
        .clk        (clk),
        .rstn       (rstn),
        .load_en    (cfg_ready),
        .clear      (load_clear),
        .abort      (abort),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .prob_idx   (dfe_prob_idx),
        .prob_in    (dfe_prob_in),
        .last_c     (last_word),
        .mono_err_c (mono_err),
        .cfg_err    (cfg_err)
    );

    // Sequencer FSM with registered DFE reset, busy, done and symbol count
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            run_len_q <= '0;
            sym_count <= '0;
            dfe_rstn  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            // Every symbol handed to the DFE is counted, saturating at all-ones
            if (dfe_en && (sym_count != '1)) begin
                sym_count <= sym_count + CNT_W'(1);
            end

            if (abort) begin
                state    <= IDLE;
                dfe_rstn <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        dfe_rstn <= 1'b0;
                        if (start) begin
                            run_len_q <= run_len;
                            sym_count <= '0;
                            busy      <= 1'b1;
                            state     <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (mono_err) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (last_word) begin
                            state <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        // Last table write lands this cycle while the DFE is still in reset
                        dfe_rstn <= 1'b1;
                        state    <= RUN;
                    end
                    RUN: begin
                        if (dfe_en && (run_len_q != '0) &&
                            ((sym_count + CNT_W'(1)) == run_len_q)) begin
                            dfe_rstn <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        dfe_rstn <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_markov_dfe_seq_ctrl.sv
// Self-checking bench for markov_dfe_seq_ctrl: table-driven runs with random
// valid gaps, plus hand-written abort, free-run and table-check sequences.
module tb_markov_dfe_seq_ctrl;

    localparam int PW = 32;
    localparam int NE = 84;
    localparam int CW = 48;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rstn, start, abort, cfg_valid, src_valid;
    logic [CW-1:0] run_len;
    logic [PW-1:0] cfg_data;
    logic          cfg_ready, src_ready, dfe_rstn, dfe_en, busy, done, cfg_err;
    logic [PW-1:0] dfe_prob_in;
    logic [31:0]   dfe_prob_idx;
    logic [CW-1:0] sym_count;

    markov_dfe_seq_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .abort        (abort),
        .run_len      (run_len),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_data     (cfg_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .dfe_rstn     (dfe_rstn),
        .dfe_en       (dfe_en),
        .dfe_prob_in  (dfe_prob_in),
        .dfe_prob_idx (dfe_prob_idx),
        .busy         (busy),
        .done         (done),
        .sym_count    (sym_count),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    // Table-driven run vectors: inputs plus expected results
    typedef struct {
        longint rl;
        int     vp;
        int     sp;
        bit     noise;
        longint exp_cnt;
        int     exp_done;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] tbl[NE];

    int n_chk = 0;
    int n_pass = 0;

    // Observed transaction history
    int          cyc, hs_n, en_n, en_bad, done_n, rise_n, rise_cyc, last_hs_cyc;
    bit          prev_rstn;
    logic [31:0] wr_idx[$];
    logic [31:0] wr_dat[$];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    task automatic clr();
        hs_n = 0; en_n = 0; en_bad = 0; done_n = 0; rise_n = 0;
        rise_cyc = -100; last_hs_cyc = -200; prev_rstn = dfe_rstn;
        wr_idx.delete(); wr_dat.delete();
    endtask

    // One clock: observe at the falling edge, return just after the rising edge
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cfg_valid && cfg_ready) begin hs_n++; last_hs_cyc = cyc; end
        if (dfe_prob_idx != NONE) begin
            wr_idx.push_back(dfe_prob_idx);
            wr_dat.push_back(dfe_prob_in);
        end
        if (dfe_en) en_n++;
        if (dfe_en && (!src_valid || !dfe_rstn)) en_bad++;
        if (done) done_n++;
        if (dfe_rstn && !prev_rstn) begin rise_n++; rise_cyc = cyc; end
        prev_rstn = dfe_rstn;
        @(posedge clk);
        #1;
    endtask

    // Cumulative table: non-decreasing inside each group of three
    task automatic gen_table();
        for (int g = 0; g < NE / 3; g++) begin
            tbl[3*g]   = $urandom_range(1000, 1 << 28);
            tbl[3*g+1] = tbl[3*g]   + $urandom_range(0, 1 << 20);
            tbl[3*g+2] = tbl[3*g+1] + $urandom_range(0, 1 << 20);
        end
    endtask

    // Start a run and stream until done, a handshake count, a symbol count, or the budget
    task automatic drive(input longint rl, input int vp, input int sp, input bit noise,
                         input int stop_hs, input int stop_en, output bit hit);
        hit = 1'b0;
        run_len = CW'(rl); start = 1'b1; cfg_valid = 1'b0; src_valid = 1'b0;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ((stop_hs >= 0 && hs_n == stop_hs) || (stop_en >= 0 && en_n == stop_en) ||
                (stop_hs < 0 && stop_en < 0 && done_n > 0)) begin
                hit = 1'b1;
                break;
            end
            cfg_valid = ($urandom_range(1, 100) <= vp);
            cfg_data  = (hs_n < NE) ? tbl[hs_n] : $urandom();
            src_valid = ($urandom_range(1, 100) <= sp);
            start     = 1'b0;
            if (noise && dfe_rstn) begin
                start     = $urandom_range(0, 1);
                cfg_valid = 1'b1;
            end
            tick();
        end
        start = 1'b0; cfg_valid = 1'b0; src_valid = 1'b0;
    endtask

    // Full load+run with result checks against the expected table and counts
    task automatic do_vec(input vec_t v);
        bit hit;
        int bad;
        clr();
        drive(v.rl, v.vp, v.sp, v.noise, -1, -1, hit);
        chk("run_timeout", hit, 1);
        tick(); tick();
        bad = 0;
        for (int k = 0; k < wr_idx.size(); k++)
            if (k >= NE || wr_idx[k] != 32'(k) || wr_dat[k] != tbl[k]) bad++;
        chk("write_count", wr_idx.size(), NE);
        chk("write_order", bad, 0);
        chk("rstn_rise_gap", rise_cyc - last_hs_cyc, 2);
        chk("rstn_rise_once", rise_n, 1);
        chk("en_pulses", en_n, v.exp_cnt);
        chk("en_gating", en_bad, 0);
        chk("done_pulses", done_n, v.exp_done);
        chk("sym_count", sym_count, v.exp_cnt);
        chk("dfe_rstn_end", dfe_rstn, 0);
        chk("busy_end", busy, 0);
        chk("cfg_err_end", cfg_err, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit hit;
        vecs[0] = '{rl: 10, vp: 100, sp: 100, noise: 0, exp_cnt: 10, exp_done: 1};
        vecs[1] = '{rl: 17, vp: 50,  sp: 50,  noise: 0, exp_cnt: 17, exp_done: 1};
        vecs[2] = '{rl: 1,  vp: 40,  sp: 70,  noise: 0, exp_cnt: 1,  exp_done: 1};
        vecs[3] = '{rl: 25, vp: 100, sp: 30,  noise: 1, exp_cnt: 25, exp_done: 1};
        vecs[4] = '{rl: 3,  vp: 60,  sp: 100, noise: 1, exp_cnt: 3,  exp_done: 1};

        cyc = 0;
        rstn = 1'b0; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; src_valid = 1'b0;
        run_len = '0; cfg_data = '0;
        tick(); tick(); tick();
        chk("rst_dfe_rstn", dfe_rstn, 0);
        chk("rst_dfe_en", dfe_en, 0);
        chk("rst_idx", dfe_prob_idx, NONE);
        chk("rst_prob_in", dfe_prob_in, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sym_count", sym_count, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rstn = 1'b1;
        tick();

        // Table-driven runs
        for (int i = 0; i < 5; i++) begin
            gen_table();
            do_vec(vecs[i]);
        end

        // Abort in LOAD after 40 words, with a word offered in the abort cycle
        gen_table();
        clr();
        drive(100, 100, 0, 0, 40, -1, hit);
        chk("abort_load_reach", hit, 1);
        abort = 1'b1; cfg_valid = 1'b1; cfg_data = tbl[40];
        tick();
        abort = 1'b0; cfg_valid = 1'b0;
        chk("abort_load_idx", dfe_prob_idx, NONE);
        chk("abort_load_busy", busy, 0);
        chk("abort_load_cfg_ready", cfg_ready, 0);
        tick(); tick();
        chk("abort_load_rstn", rise_n, 0);
        chk("abort_load_done", done_n, 0);
        do_vec('{rl: 5, vp: 100, sp: 100, noise: 0, exp_cnt: 5, exp_done: 1});

        // Abort in RUN after 5 symbols
        gen_table();
        clr();
        drive(100, 100, 100, 0, -1, 5, hit);
        chk("abort_run_reach", hit, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_run_rstn", dfe_rstn, 0);
        chk("abort_run_busy", busy, 0);
        tick(); tick();
        chk("abort_run_done", done_n, 0);
        chk("abort_run_count", sym_count, 5);
        do_vec('{rl: 2, vp: 70, sp: 70, noise: 0, exp_cnt: 2, exp_done: 1});

        // Free-run (run_len 0) for 1000 symbols, then abort
        gen_table();
        clr();
        drive(0, 100, 100, 0, -1, 1000, hit);
        chk("free_run_reach", hit, 1);
        tick(); tick(); tick();
        chk("free_run_count", sym_count, 1000);
        chk("free_run_still_on", dfe_rstn, 1);
        chk("free_run_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        chk("free_run_abort_busy", busy, 0);
        chk("free_run_abort_rstn", dfe_rstn, 0);
        chk("free_run_hold_count", sym_count, 1000);
        chk("free_run_done", done_n, 0);

        // Table with word 4 below word 3
        gen_table();
        tbl[4] = tbl[3] - 1;
`ifdef MARKOV_SEQ_MONO_CHECK_EN
        clr();
        drive(4, 100, 100, 0, 5, -1, hit);
        chk("mono_reach", hit, 1);
        cfg_valid = 1'b1; cfg_data = tbl[5];
        for (int k = 0; k < 6; k++) tick();
        cfg_valid = 1'b0;
        chk("mono_cfg_err", cfg_err, 1);
        chk("mono_busy", busy, 0);
        chk("mono_words", hs_n, 5);
        chk("mono_no_rstn", rise_n, 0);
        chk("mono_done", done_n, 0);
`else
        do_vec('{rl: 4, vp: 100, sp: 100, noise: 0, exp_cnt: 4, exp_done: 1});
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
